// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed scanner for a 4-digit seven-segment display.
// Holds a 16-bit hex value plus 4 dot flags and steps through digits 0..3,
// holding each for DWELL_CNT clk_sys cycles. Drives seg7decoder with the
// digit index, nibble and dot, plus a per-digit enable. New values are
// only applied when the index wraps 3->0, so a frame never mixes values.
//
// Ports:
//   clk_sys         in   system clock
//   rst_n           in   asynchronous active-low reset
//   VALUE_IN[15:0]  in   hex value; digit n = VALUE_IN[4n+3:4n]
//   DOTS_IN[3:0]    in   dot flag per digit
//   LOAD_IN         in   1-cycle pulse: capture VALUE_IN/DOTS_IN as pending
//   BLANK_IN[3:0]   in   live per-digit force-off mask
//   LOAD_ACK_OUT    out  1-cycle pulse when a pending value is applied
//   FRAME_OUT       out  1-cycle pulse marking the 3->0 index wrap
//   SEG_SELECT_OUT  out  digit index to seg7decoder
//   BIN_OUT[3:0]    out  nibble of the current digit
//   DOT_OUT         out  dot of the current digit
//   DIGIT_EN_OUT    out  1 = current digit lit
module seg7_scan #(
    parameter int unsigned DWELL_CNT     = 100000,
    parameter int unsigned CNT_W         = 17,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] VALUE_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        LOAD_IN,
    input  logic [3:0]  BLANK_IN,
    output logic        LOAD_ACK_OUT,
    output logic        FRAME_OUT,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        DIGIT_EN_OUT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [15:0]      disp_val_q;
    logic [3:0]       disp_dots_q;
    logic [15:0]      pend_val_q;
    logic [3:0]       pend_dots_q;
    logic             pend_q;

    logic             frame_q;
    logic             ack_q;
    logic [1:0]       seg_q;
    logic [3:0]       bin_q;
    logic             dot_q;
    logic             en_q;

    logic             terminal;
    logic             wrap;
    logic [3:0]       sup;
    logic [3:0]       cur_nib;

    assign terminal = (cnt_q == CNT_LAST);
    assign wrap     = terminal && (idx_q == 2'd3);
    assign cur_nib  = disp_val_q[{idx_q, 2'b00} +: 4];

    // A digit is suppressed only if it is a zero with no dot and everything
    // above it is suppressed too; digit 0 always shows.
    always_comb begin
        sup = 4'b0000;
        if (BLANK_LEADING != 0) begin
            sup[3] = (disp_val_q[15:12] == 4'h0) && !disp_dots_q[3];
            sup[2] = sup[3] && (disp_val_q[11:8] == 4'h0) && !disp_dots_q[2];
            sup[1] = sup[2] && (disp_val_q[7:4] == 4'h0) && !disp_dots_q[1];
        end
    end

    // Dwell counter and digit index.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else if (terminal) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Pending/display registers. A load on the wrap cycle bypasses the
    // pending regs and is applied straight from the live inputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            disp_val_q  <= 16'h0000;
            disp_dots_q <= 4'h0;
            pend_val_q  <= 16'h0000;
            pend_dots_q <= 4'h0;
            pend_q      <= 1'b0;
        end else if (wrap) begin
            pend_q <= 1'b0;
            if (LOAD_IN) begin
                disp_val_q  <= VALUE_IN;
                disp_dots_q <= DOTS_IN;
            end else if (pend_q) begin
                disp_val_q  <= pend_val_q;
                disp_dots_q <= pend_dots_q;
            end
        end else if (LOAD_IN) begin
            pend_q      <= 1'b1;
            pend_val_q  <= VALUE_IN;
            pend_dots_q <= DOTS_IN;
        end
    end

    // Output registers: all digit outputs update together, one cycle after
    // the index/display state. FRAME_OUT/LOAD_ACK_OUT are registered copies
    // of the wrap event so every output is glitch-free.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 1'b0;
            ack_q   <= 1'b0;
            seg_q   <= 2'd0;
            bin_q   <= 4'h0;
            dot_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            frame_q <= wrap;
            ack_q   <= wrap && (pend_q || LOAD_IN);
            seg_q   <= idx_q;
            bin_q   <= cur_nib;
            dot_q   <= disp_dots_q[idx_q];
            en_q    <= !BLANK_IN[idx_q] && !sup[idx_q];
        end
    end

    assign LOAD_ACK_OUT   = ack_q;
    assign FRAME_OUT      = frame_q;
    assign SEG_SELECT_OUT = seg_q;
    assign BIN_OUT        = bin_q;
    assign DOT_OUT        = dot_q;
    assign DIGIT_EN_OUT   = en_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed, table-driven bench for seg7_scan with DWELL_CNT=4.
// Time base: k counts rising edges since the last reset release; outputs are
// sampled 1 time unit after each edge. Frames wrap at edges k = 16m, and the
// digit d of the frame starting at edge B is visible after edges
// B+1+4d .. B+4+4d (sampled at B+2+4d).
module tb_seg7_scan;

    logic        clk_sys;
    logic        rst_n;
    logic [15:0] VALUE_IN;
    logic [3:0]  DOTS_IN;
    logic        LOAD_IN;
    logic [3:0]  BLANK_IN;
    logic        LOAD_ACK_OUT;
    logic        FRAME_OUT;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;
    logic        DIGIT_EN_OUT;

    seg7_scan #(
        .DWELL_CNT     (4),
        .CNT_W         (3),
        .BLANK_LEADING (1)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .VALUE_IN       (VALUE_IN),
        .DOTS_IN        (DOTS_IN),
        .LOAD_IN        (LOAD_IN),
        .BLANK_IN       (BLANK_IN),
        .LOAD_ACK_OUT   (LOAD_ACK_OUT),
        .FRAME_OUT      (FRAME_OUT),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .BIN_OUT        (BIN_OUT),
        .DOT_OUT        (DOT_OUT),
        .DIGIT_EN_OUT   (DIGIT_EN_OUT)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  blank;
        logic [15:0] exp_bin;
        logic [3:0]  exp_dot;
        logic [3:0]  exp_en;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    int          k;
    int          ack_cnt;
    int          n_vec;
    int          n_err;
    int          base;
    logic [15:0] prev;
    logic [15:0] eb;
    logic [3:0]  ed;
    logic [3:0]  ee;
    logic        saw_one;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        k++;
        if (LOAD_ACK_OUT) ack_cnt++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic next_base();
        base = (k / 16 + 1) * 16;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ack"}, 32'(LOAD_ACK_OUT), 0);
        chk({tag, " frame"}, 32'(FRAME_OUT), 0);
        chk({tag, " seg"}, 32'(SEG_SELECT_OUT), 0);
        chk({tag, " bin"}, 32'(BIN_OUT), 0);
        chk({tag, " dot"}, 32'(DOT_OUT), 0);
        chk({tag, " en"}, 32'(DIGIT_EN_OUT), 0);
    endtask

    // Check digit d of the frame whose wrap edge is b.
    task automatic chk_digit(input int b, input int d, input logic [3:0] bin,
                             input logic dot, input logic en);
        run_to(b + 2 + 4 * d);
        chk("digit seg", 32'(SEG_SELECT_OUT), 32'(d));
        chk("digit bin", 32'(BIN_OUT), 32'(bin));
        chk("digit dot", 32'(DOT_OUT), 32'(dot));
        chk("digit en", 32'(DIGIT_EN_OUT), 32'(en));
    endtask

    initial begin
        //            value    dots     blank    exp_bin  exp_dot  exp_en
        vecs[0] = '{16'h12AB, 4'b0010, 4'b0000, 16'h12AB, 4'b0010, 4'b1111};
        vecs[1] = '{16'h00C3, 4'b0000, 4'b0000, 16'h00C3, 4'b0000, 4'b0011};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0001};
        vecs[3] = '{16'h0005, 4'b0100, 4'b0000, 16'h0005, 4'b0100, 4'b0111};
        vecs[4] = '{16'h0005, 4'b0100, 4'b0001, 16'h0005, 4'b0100, 4'b0110};
        vecs[5] = '{16'h8000, 4'b0000, 4'b0000, 16'h8000, 4'b0000, 4'b1111};
        vecs[6] = '{16'h0F00, 4'b1000, 4'b0000, 16'h0F00, 4'b1000, 4'b1111};
        vecs[7] = '{16'hFFFF, 4'b1111, 4'b1010, 16'hFFFF, 4'b1111, 4'b0101};
        vecs[8] = '{16'h0030, 4'b0001, 4'b0000, 16'h0030, 4'b0001, 4'b0011};
        vecs[9] = '{16'h0000, 4'b0001, 4'b0000, 16'h0000, 4'b0001, 4'b0001};

        n_vec = 0; n_err = 0; k = 0; ack_cnt = 0;
        rst_n = 1'b0; VALUE_IN = 16'h0; DOTS_IN = 4'h0; LOAD_IN = 1'b0; BLANK_IN = 4'h0;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        k = 0;

        // Scan timing: index steps every 4 cycles, FRAME_OUT every 16
        for (int i = 1; i <= 33; i++) begin
            tick();
            chk("scan seg", 32'(SEG_SELECT_OUT), 32'(((k - 1) / 4) % 4));
            chk("scan frame", 32'(FRAME_OUT), (k % 16 == 0) ? 32'd1 : 32'd0);
        end

        // Table: mid-frame load, applied at the wrap, next frame checked
        prev = 16'h0000;
        for (int v = 0; v < NVEC; v++) begin
            next_base();
            run_to(base + 4);
            VALUE_IN = vecs[v].value;
            DOTS_IN  = vecs[v].dots;
            LOAD_IN  = 1'b1;
            tick();
            LOAD_IN  = 1'b0;
            VALUE_IN = 16'hDEAD;
            DOTS_IN  = 4'hF;
            run_to(base + 15);
            chk("no early ack", 32'(LOAD_ACK_OUT), 0);
            tick();
            chk("wrap ack", 32'(LOAD_ACK_OUT), 1);
            chk("wrap frame", 32'(FRAME_OUT), 1);
            eb = prev;
            chk("old digit3 held", 32'(BIN_OUT), 32'(eb[15:12]));
            BLANK_IN = vecs[v].blank;
            eb = vecs[v].exp_bin;
            ed = vecs[v].exp_dot;
            ee = vecs[v].exp_en;
            for (int d = 0; d < 4; d++) begin
                chk_digit(base + 16, d, eb[4 * d +: 4], ed[d], ee[d]);
                if (d == 0) chk("ack single", 32'(LOAD_ACK_OUT), 0);
            end
            BLANK_IN = 4'h0;
            prev = vecs[v].value;
        end

        // Two loads in one frame: last wins, single ack
        next_base();
        run_to(base + 3);
        VALUE_IN = 16'h1111; DOTS_IN = 4'h0; LOAD_IN = 1'b1;
        tick();
        LOAD_IN = 1'b0;
        run_to(base + 9);
        VALUE_IN = 16'h2222; LOAD_IN = 1'b1;
        tick();
        LOAD_IN = 1'b0; VALUE_IN = 16'h0;
        ack_cnt = 0;
        saw_one = 1'b0;
        while (k < base + 33) begin
            tick();
            if (k > base + 16 && BIN_OUT == 4'h1) saw_one = 1'b1;
        end
        chk("last-wins ack count", 32'(ack_cnt), 1);
        chk("1111 never shown", 32'(saw_one), 0);
        for (int d = 0; d < 4; d++) begin
            next_base();
            chk_digit(base, d, 4'h2, 1'b0, 1'b1);
        end

        // Load coincident with the wrap cycle
        next_base();
        run_to(base + 15);
        VALUE_IN = 16'h00C3; DOTS_IN = 4'h0; LOAD_IN = 1'b1;
        ack_cnt = 0;
        tick();
        LOAD_IN = 1'b0; VALUE_IN = 16'h0;
        chk("coincident ack", 32'(LOAD_ACK_OUT), 1);
        chk_digit(base + 16, 0, 4'h3, 1'b0, 1'b1);
        chk_digit(base + 16, 1, 4'hC, 1'b0, 1'b1);
        chk_digit(base + 16, 2, 4'h0, 1'b0, 1'b0);
        chk_digit(base + 16, 3, 4'h0, 1'b0, 1'b0);
        run_to(base + 33);
        chk("coincident no re-ack", 32'(ack_cnt), 1);

        // Load on the cycle after a wrap goes to the next frame
        next_base();
        run_to(base + 16);
        VALUE_IN = 16'h0070; DOTS_IN = 4'h0; LOAD_IN = 1'b1;
        ack_cnt = 0;
        tick();
        LOAD_IN = 1'b0; VALUE_IN = 16'h0;
        chk("post-wrap no ack", 32'(LOAD_ACK_OUT), 0);
        chk_digit(base + 16, 0, 4'h3, 1'b0, 1'b1);
        run_to(base + 32);
        chk("post-wrap ack next", 32'(LOAD_ACK_OUT), 1);
        chk("post-wrap ack count", 32'(ack_cnt), 1);
        chk_digit(base + 32, 0, 4'h0, 1'b0, 1'b1);
        chk_digit(base + 32, 1, 4'h7, 1'b0, 1'b1);
        chk_digit(base + 32, 2, 4'h0, 1'b0, 1'b0);

        // BLANK_IN is live with one cycle of latency
        next_base();
        run_to(base + 1);
        chk("blank before", 32'(DIGIT_EN_OUT), 1);
        BLANK_IN = 4'b0001;
        tick();
        chk("blank applied", 32'(DIGIT_EN_OUT), 0);
        chk("blank bin kept", 32'(BIN_OUT), 0);
        BLANK_IN = 4'b0000;
        tick();
        chk("blank released", 32'(DIGIT_EN_OUT), 1);

        // Reset mid-frame discards pending data
        next_base();
        run_to(base + 4);
        VALUE_IN = 16'h4321; DOTS_IN = 4'hF; LOAD_IN = 1'b1;
        tick();
        LOAD_IN = 1'b0;
        run_to(base + 8);
        chk("pre-reset seg", 32'(SEG_SELECT_OUT), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(posedge clk_sys);
        #1;
        chk_all_zero("held reset");
        rst_n = 1'b1;
        k = 0;
        ack_cnt = 0;
        for (int d = 0; d < 4; d++)
            chk_digit(16, d, 4'h0, 1'b0, (d == 0));
        run_to(40);
        chk("no ack after reset", 32'(ack_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
